clk_period_meter: RTL and testbench

- Fast-domain monitor for a divided timebase such as the 1 Hz meter tick.
- Synchronises a slow clock or pulse signal into inclk and measures the inclk-cycle count between consecutive rising edges.
- Reports each measured period with a one-cycle valid strobe and a tolerance flag against the expected period.
- Flags a stalled timebase, i.e. no edge arriving within a timeout.

---
 rtl/clk_period_meter.sv | 127 ++++++++++++
 tb/tb_clk_period_meter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures the inclk-cycle spacing between rising edges of an asynchronous slow signal,
// flags each result against a tolerance window and reports a stalled timebase.
module clk_period_meter #(
  parameter int unsigned num_bits        = 31,
  parameter int unsigned expected_period = 100000000,
  parameter int unsigned tolerance       = 1000,
  parameter int unsigned timeout         = 200000000
) (
  input  logic              inclk,
  input  logic              reset_n,
  input  logic              slowclk,
  output logic [num_bits:0] period,
  output logic              period_valid,
  output logic              in_tol,
  output logic              stalled,
  output logic              edge_seen
);

  localparam int unsigned W = num_bits + 1;
  localparam logic [num_bits:0] EXP_C = W'(expected_period);
  localparam logic [num_bits:0] TOL_C = W'(tolerance);
  localparam logic [num_bits:0] TO_C  = W'(timeout);
  localparam logic [num_bits:0] ONE_C = W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALL   = 2'd2
  } state_t;

  state_t            state_q;
  logic              s1_q, s2_q, s3_q;
  logic [num_bits:0] cnt_q;
  logic [num_bits:0] period_q;
  logic              period_valid_q;
  logic              in_tol_q;
  logic              stalled_q;
  logic              edge_seen_q;

  logic              rise_s;
  logic [num_bits:0] cnt_inc_s;
  logic [num_bits:0] diff_s;
  logic              in_tol_s;
  logic              timeout_hit_s;

  assign rise_s        = s2_q & ~s3_q;
  assign cnt_inc_s     = cnt_q + ONE_C;
  assign timeout_hit_s = (cnt_inc_s >= TO_C);

  // Absolute deviation from nominal, ordered subtraction so nothing wraps.
  always_comb begin
    diff_s = '0;
    if (cnt_inc_s >= EXP_C) begin
      diff_s = cnt_inc_s - EXP_C;
    end else begin
      diff_s = EXP_C - cnt_inc_s;
    end
  end

  assign in_tol_s = (diff_s <= TOL_C);

  // Synchroniser, measurement FSM and registered result outputs.
  always_ff @(posedge inclk) begin
    if (!reset_n) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      cnt_q          <= '0;
      state_q        <= ST_IDLE;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      in_tol_q       <= 1'b0;
      stalled_q      <= 1'b0;
      edge_seen_q    <= 1'b0;
    end else begin
      s1_q           <= slowclk;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      period_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (rise_s) begin
            state_q     <= ST_MEASURE;
            edge_seen_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_MEASURE: begin
          // A rise coinciding with the timeout still yields a period.
          if (rise_s) begin
            period_q       <= cnt_inc_s;
            period_valid_q <= 1'b1;
            in_tol_q       <= in_tol_s;
            cnt_q          <= '0;
          end else if (timeout_hit_s) begin
            stalled_q <= 1'b1;
            state_q   <= ST_STALL;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        ST_STALL: begin
          if (rise_s) begin
            stalled_q <= 1'b0;
            state_q   <= ST_MEASURE;
            cnt_q     <= '0;
          end else begin
            state_q <= ST_STALL;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign in_tol       = in_tol_q;
  assign stalled      = stalled_q;
  assign edge_seen    = edge_seen_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Drives slow waveforms (directed and random, with asynchronous edge placement) into two
// meters differing only in tolerance, and checks every cycle against an edge-timing model.
module tb_clk_period_meter;

  localparam int EXP = 10;
  localparam int TO  = 25;

  logic        inclk;
  logic        reset_n;
  logic        slowclk;
  logic [31:0] period0, period2;
  logic        valid0, valid2, tol0, tol2, stall0, stall2, seen0, seen2;

  int nerr;
  int nchk;

  // reference model state: edge timestamps rather than counters
  int   t;
  int   last;
  int   mode;      // 0 no edge yet, 1 measuring, 2 stalled
  logic p1, p2, p3;
  int   m_period;
  logic m_valid, m_tol0, m_tol2, m_stall, m_seen;

  clk_period_meter #(.num_bits(31), .expected_period(EXP), .tolerance(0), .timeout(TO)) u_tol0 (
    .inclk(inclk), .reset_n(reset_n), .slowclk(slowclk), .period(period0),
    .period_valid(valid0), .in_tol(tol0), .stalled(stall0), .edge_seen(seen0));

  clk_period_meter #(.num_bits(31), .expected_period(EXP), .tolerance(2), .timeout(TO)) u_tol2 (
    .inclk(inclk), .reset_n(reset_n), .slowclk(slowclk), .period(period2),
    .period_valid(valid2), .in_tol(tol2), .stalled(stall2), .edge_seen(seen2));

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0d", tag, obs, exp, t);
    end
  endtask

  // Edge seen at posedge k is acted on at posedge k+2; periods are timestamp differences.
  task automatic model_step(input logic v, input logic rn);
    int d;
    if (!rn) begin
      p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
      mode = 0; m_period = 0; m_valid = 1'b0;
      m_tol0 = 1'b0; m_tol2 = 1'b0; m_stall = 1'b0; m_seen = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (p2 && !p3) begin
        if (mode == 1) begin
          m_period = t - last;
          m_valid  = 1'b1;
          d        = (m_period > EXP) ? m_period - EXP : EXP - m_period;
          m_tol0   = (d <= 0);
          m_tol2   = (d <= 2);
        end
        mode = 1; last = t; m_stall = 1'b0; m_seen = 1'b1;
      end else if (mode == 1 && (t - last) == TO) begin
        m_stall = 1'b1;
        mode = 2;
      end
      p3 = p2; p2 = p1; p1 = v;
    end
    t++;
  endtask

  task automatic cyc(input logic val, input bit rnd);
    int unsigned dly;
    dly = rnd ? $urandom_range(0, 8) : 2;
    #(dly);
    slowclk = val;
    @(posedge inclk);
    model_step(slowclk, reset_n);
    #1;
    chk("period",       period0,        32'(m_period));
    chk("period_t2",    period2,        32'(m_period));
    chk("period_valid", {31'd0, valid0}, {31'd0, m_valid});
    chk("in_tol_t0",    {31'd0, tol0},   {31'd0, m_tol0});
    chk("in_tol_t2",    {31'd0, tol2},   {31'd0, m_tol2});
    chk("stalled",      {31'd0, stall0}, {31'd0, m_stall});
    chk("edge_seen",    {31'd0, seen0},  {31'd0, m_seen});
  endtask

  task automatic wave(input int hi, input int lo, input int reps, input bit rnd);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) cyc(1'b1, rnd);
      for (int i = 0; i < lo; i++) cyc(1'b0, rnd);
    end
  endtask

  initial begin
    nerr = 0; nchk = 0; t = 0; last = 0; mode = 0;
    p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
    m_period = 0; m_valid = 1'b0; m_tol0 = 1'b0; m_tol2 = 1'b0; m_stall = 1'b0; m_seen = 1'b0;
    reset_n = 1'b0;
    slowclk = 1'b0;
    @(posedge inclk);
    model_step(slowclk, reset_n);
    #1;
    cyc(1'b0, 1'b0);
    reset_n = 1'b1;

    wave(5, 5, 6, 1'b0);           // period 10, in tolerance
    wave(6, 6, 5, 1'b0);           // period 12: out for tol 0, in for tol 2
    wave(5, 5, 3, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0);  // stall, period holds 10
    chk("stall_hold_period", period0, 32'd10);
    chk("stall_level", {31'd0, stall0}, 32'd1);
    wave(5, 5, 4, 1'b0);           // resume: first rise clears stall, no strobe
    wave(12, 13, 3, 1'b0);         // rise exactly at timeout: period 25
    wave(13, 13, 2, 1'b0);         // one cycle late: stalls every period
    wave(5, 5, 3, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    reset_n = 1'b0;                // reset mid-measurement
    cyc(1'b1, 1'b0);
    reset_n = 1'b1;
    chk("post_reset_period", period0, 32'd0);
    wave(2, 5, 4, 1'b0);

    // random waveforms with single-cycle glitches and occasional resets
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        cyc(1'($urandom_range(0, 1)), 1'b1);
        reset_n = 1'b1;
      end
      wave($urandom_range(1, 14), $urandom_range(1, 16), 1, 1'b1);
    end
    wave(5, 5, 3, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
